// File: rtl/rb_pkg.sv
// Shared RadioBox definitions: DDS channel FSM states, shadow select codes
// and phase-config widths.
package rb_pkg;

  localparam int RB_PHASE_W      = 48;
  localparam int RB_PHASE_DATA_W = 97;

  typedef enum logic [1:0] {
    RB_DDS_ST_OFF,
    RB_DDS_ST_CLK_ON,
    RB_DDS_ST_RUN,
    RB_DDS_ST_RST
  } rb_dds_st_e;

  localparam logic [1:0] RB_CFG_INC_LO = 2'd0;
  localparam logic [1:0] RB_CFG_INC_HI = 2'd1;
  localparam logic [1:0] RB_CFG_OFS    = 2'd2;

endpackage

// File: rtl/rb_dds_shadow.sv
// Shadow registers for one DDS channel: bus write decode and assembly of the
// 48-bit phase increment and offset handed to the DDS on commit.
module rb_dds_shadow
  import rb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_i,
  input  logic [1:0]            sel_i,
  input  logic [31:0]           wdata_i,
  output logic [RB_PHASE_W-1:0] inc_o,
  output logic [RB_PHASE_W-1:0] ofs_o
);

  logic [31:0] inc_lo_q, inc_lo_d;
  logic [31:0] inc_hi_q, inc_hi_d;
  logic [31:0] ofs_q, ofs_d;

  always_comb begin
    inc_lo_d = inc_lo_q;
    inc_hi_d = inc_hi_q;
    ofs_d    = ofs_q;
    if (wr_i) begin
      case (sel_i)
        RB_CFG_INC_LO: inc_lo_d = wdata_i;
        RB_CFG_INC_HI: inc_hi_d = wdata_i;
        RB_CFG_OFS:    ofs_d    = wdata_i;
        default:       ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_lo_q <= '0;
      inc_hi_q <= '0;
      ofs_q    <= '0;
    end else begin
      inc_lo_q <= inc_lo_d;
      inc_hi_q <= inc_hi_d;
      ofs_q    <= ofs_d;
    end
  end

  // Only the top half of INC_LO reaches the DDS; the offset is left-aligned.
  assign inc_o = {inc_hi_q, inc_lo_q[31:16]};
  assign ofs_o = {ofs_q, 16'h0000};

endmodule

// File: rtl/rb_dds_ctrl.sv
// DDS channel sequencer: clock-enable/reset bring-up and tear-down, and
// atomic one-beat delivery of committed phase configuration.
module rb_dds_ctrl
  import rb_pkg::*;
#(
  parameter int unsigned SETTLE = 3
) (
  input  logic                       clk_adc_125mhz,
  input  logic                       adc_rst_i,
  input  logic                       en_i,
  input  logic                       cfg_wr_i,
  input  logic [1:0]                 cfg_sel_i,
  input  logic [31:0]                cfg_wdata_i,
  input  logic                       commit_i,
  input  logic                       resync_i,
  output logic                       dds_clk_en_o,
  output logic                       dds_rstn_o,
  output logic                       phase_vld_o,
  output logic [RB_PHASE_DATA_W-1:0] phase_data_o,
  output logic                       busy_o,
  output logic                       pend_o
);

  // Handshake: phase_vld_o is a one-cycle push with no back-pressure; the
  // DDS must accept phase_data_o in every cycle phase_vld_o is high.

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  rb_dds_st_e                 state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic                       pend_q, pend_d;
  logic                       rs_q, rs_d;
  logic                       clk_en_q, clk_en_d;
  logic                       rstn_q, rstn_d;
  logic                       vld_q, vld_d;
  logic                       busy_q, busy_d;
  logic [RB_PHASE_DATA_W-1:0] data_q, data_d;
  logic [RB_PHASE_W-1:0]      inc, ofs;
  logic                       deliver;

  rb_dds_shadow u_shadow (
    .clk     (clk_adc_125mhz),
    .rst     (adc_rst_i),
    .wr_i    (cfg_wr_i),
    .sel_i   (cfg_sel_i),
    .wdata_i (cfg_wdata_i),
    .inc_o   (inc),
    .ofs_o   (ofs)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RB_DDS_ST_OFF: begin
        if (en_i) begin
          state_d = RB_DDS_ST_CLK_ON;
          cnt_d   = CNT_INIT;
        end
      end
      RB_DDS_ST_CLK_ON: begin
        if (!en_i) begin
          state_d = RB_DDS_ST_RST;
          cnt_d   = CNT_INIT;
        end else if (cnt_q == 4'd0) begin
          state_d = RB_DDS_ST_RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RB_DDS_ST_RUN: begin
        if (!en_i) begin
          state_d = RB_DDS_ST_RST;
          cnt_d   = CNT_INIT;
        end
      end
      RB_DDS_ST_RST: begin
        if (cnt_q == 4'd0) state_d = RB_DDS_ST_OFF;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = RB_DDS_ST_OFF;
    endcase

    deliver = (state_q == RB_DDS_ST_RUN) && pend_q;
    // Entering RUN forces a delivery so the DDS always leaves reset with the
    // current configuration.
    pend_d  = (pend_q && !deliver) || commit_i ||
              ((state_d == RB_DDS_ST_RUN) && (state_q != RB_DDS_ST_RUN));
    rs_d    = (rs_q && !deliver) || (commit_i && resync_i);
    data_d  = deliver ? {rs_q, ofs, inc}
                      : {1'b0, data_q[RB_PHASE_DATA_W-2:0]};

    clk_en_d = (state_q != RB_DDS_ST_OFF);
    rstn_d   = (state_q == RB_DDS_ST_RUN);
    busy_d   = (state_q == RB_DDS_ST_CLK_ON) || (state_q == RB_DDS_ST_RST);
    vld_d    = deliver;
  end

  always_ff @(posedge clk_adc_125mhz or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      state_q  <= RB_DDS_ST_OFF;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      rs_q     <= 1'b0;
      clk_en_q <= 1'b0;
      rstn_q   <= 1'b0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      rs_q     <= rs_d;
      clk_en_q <= clk_en_d;
      rstn_q   <= rstn_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      data_q   <= data_d;
    end
  end

  assign dds_clk_en_o = clk_en_q;
  assign dds_rstn_o   = rstn_q;
  assign phase_vld_o  = vld_q;
  assign phase_data_o = data_q;
  assign busy_o       = busy_q;
  assign pend_o       = pend_q;

endmodule

// File: tb/tb_rb_dds_ctrl.sv
// Self-checking bench for rb_dds_ctrl: scenario tasks plus a beat scoreboard
// fed by a behavioural model of the shadow registers.
module tb_rb_dds_ctrl;
  import rb_pkg::*;

  localparam int S = 3;

  logic        clk_adc_125mhz = 1'b0;
  logic        adc_rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic        cfg_wr_i = 1'b0;
  logic [1:0]  cfg_sel_i = 2'd0;
  logic [31:0] cfg_wdata_i = 32'h0;
  logic        commit_i = 1'b0;
  logic        resync_i = 1'b0;
  logic        dds_clk_en_o;
  logic        dds_rstn_o;
  logic        phase_vld_o;
  logic [96:0] phase_data_o;
  logic        busy_o;
  logic        pend_o;

  int checks = 0;
  int failures = 0;
  logic [96:0] exp_q[$];
  logic [31:0] m_lo = 32'h0, m_hi = 32'h0, m_ofs = 32'h0;

  always #5 clk_adc_125mhz = ~clk_adc_125mhz;

  rb_dds_ctrl #(.SETTLE(S)) dut (
    .clk_adc_125mhz (clk_adc_125mhz),
    .adc_rst_i      (adc_rst_i),
    .en_i           (en_i),
    .cfg_wr_i       (cfg_wr_i),
    .cfg_sel_i      (cfg_sel_i),
    .cfg_wdata_i    (cfg_wdata_i),
    .commit_i       (commit_i),
    .resync_i       (resync_i),
    .dds_clk_en_o   (dds_clk_en_o),
    .dds_rstn_o     (dds_rstn_o),
    .phase_vld_o    (phase_vld_o),
    .phase_data_o   (phase_data_o),
    .busy_o         (busy_o),
    .pend_o         (pend_o)
  );

  // Beat the DDS should receive from the model's shadow contents.
  function automatic logic [96:0] exp_beat(input logic rs);
    logic [47:0] inc, ofs;
    inc = ({16'h0, m_hi} << 16) | 48'(m_lo >> 16);
    ofs = 48'(m_ofs) * 48'd65536;
    return {rs, ofs, inc};
  endfunction

  // One clock: model absorbs the write, then the beat due this cycle is checked.
  task automatic step();
    logic [96:0] e;
    if (cfg_wr_i) begin
      case (cfg_sel_i)
        2'd0: m_lo = cfg_wdata_i;
        2'd1: m_hi = cfg_wdata_i;
        2'd2: m_ofs = cfg_wdata_i;
        default: ;
      endcase
    end
    @(posedge clk_adc_125mhz);
    #1;
    cfg_wr_i = 1'b0;
    commit_i = 1'b0;
    resync_i = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (phase_vld_o !== 1'b1) begin
        failures++;
        $display("FAIL beat_missing: phase_vld_o=%b expected 1", phase_vld_o);
      end else if (phase_data_o !== e) begin
        failures++;
        $display("FAIL beat_data: got %h expected %h", phase_data_o, e);
      end
    end else if (phase_vld_o !== 1'b0) begin
      failures++;
      $display("FAIL unexpected_beat: phase_vld_o=%b expected 0 data=%h", phase_vld_o, phase_data_o);
    end else if (phase_data_o[96] !== 1'b0) begin
      failures++;
      $display("FAIL idle_resync: got %b expected 0", phase_data_o[96]);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_adc_125mhz);
    #1;
    checks += 6;
    if (dds_clk_en_o !== 1'b0) begin failures++; $display("FAIL rst_clk_en: got %b expected 0", dds_clk_en_o); end
    if (dds_rstn_o !== 1'b0) begin failures++; $display("FAIL rst_rstn: got %b expected 0", dds_rstn_o); end
    if (phase_vld_o !== 1'b0) begin failures++; $display("FAIL rst_vld: got %b expected 0", phase_vld_o); end
    if (phase_data_o !== 97'h0) begin failures++; $display("FAIL rst_data: got %h expected 0", phase_data_o); end
    if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
    if (pend_o !== 1'b0) begin failures++; $display("FAIL rst_pend: got %b expected 0", pend_o); end
    adc_rst_i = 1'b0;
    step();
  endtask

  task automatic test_bringup();
    en_i = 1'b1;
    step();  // edge 0
    checks++;
    if (dds_clk_en_o !== 1'b0) begin failures++; $display("FAIL up_clk_en_e0: got %b expected 0", dds_clk_en_o); end
    step();  // edge 1
    checks += 3;
    if (dds_clk_en_o !== 1'b1) begin failures++; $display("FAIL up_clk_en_e1: got %b expected 1", dds_clk_en_o); end
    if (dds_rstn_o !== 1'b0) begin failures++; $display("FAIL up_rstn_e1: got %b expected 0", dds_rstn_o); end
    if (busy_o !== 1'b1) begin failures++; $display("FAIL up_busy: got %b expected 1", busy_o); end
    for (int e = 2; e <= S; e++) begin
      step();
      checks++;
      if (dds_rstn_o !== 1'b0) begin failures++; $display("FAIL up_rstn_early: edge %0d got %b expected 0", e, dds_rstn_o); end
    end
    exp_q.push_back(exp_beat(1'b0));
    step();  // edge 1+S
    checks += 3;
    if (dds_rstn_o !== 1'b1) begin failures++; $display("FAIL up_rstn: got %b expected 1", dds_rstn_o); end
    if (phase_vld_o !== 1'b1) begin failures++; $display("FAIL up_vld: got %b expected 1", phase_vld_o); end
    if (busy_o !== 1'b0) begin failures++; $display("FAIL up_busy_run: got %b expected 0", busy_o); end
    step();
    checks++;
    if (pend_o !== 1'b0) begin failures++; $display("FAIL up_pend: got %b expected 0", pend_o); end
  endtask

  task automatic test_commit();
    cfg_wr_i = 1'b1; cfg_sel_i = 2'd0; cfg_wdata_i = 32'hABCD1234; step();
    cfg_wr_i = 1'b1; cfg_sel_i = 2'd1; cfg_wdata_i = 32'h00112233; step();
    cfg_wr_i = 1'b1; cfg_sel_i = 2'd2; cfg_wdata_i = 32'h80000000; step();
    commit_i = 1'b1; resync_i = 1'b0; step();
    exp_q.push_back(exp_beat(1'b0));
    step();
    checks += 3;
    if (phase_data_o[47:0] !== 48'h00112233ABCD) begin failures++; $display("FAIL commit_inc: got %h expected 00112233abcd", phase_data_o[47:0]); end
    if (phase_data_o[95:48] !== 48'h800000000000) begin failures++; $display("FAIL commit_ofs: got %h expected 800000000000", phase_data_o[95:48]); end
    if (phase_data_o[96] !== 1'b0) begin failures++; $display("FAIL commit_resync: got %b expected 0", phase_data_o[96]); end
    step();
    checks++;
    if (phase_data_o[95:0] !== {48'h800000000000, 48'h00112233ABCD}) begin
      failures++; $display("FAIL commit_hold: got %h expected 80000000000000112233abcd", phase_data_o[95:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi;
    hi = $urandom;
    cfg_wr_i = 1'b1; cfg_sel_i = 2'd1; cfg_wdata_i = hi; commit_i = 1'b1; step();
    exp_q.push_back(exp_beat(1'b0));
    commit_i = 1'b1; step();
    checks++;
    if (phase_data_o[47:16] !== hi) begin failures++; $display("FAIL b2b_new_hi: got %h expected %h", phase_data_o[47:16], hi); end
    exp_q.push_back(exp_beat(1'b0));
    step();
    step();
  endtask

  task automatic test_random();
    logic c, r;
    for (int i = 0; i < 80; i++) begin
      cfg_wr_i = 1'($urandom_range(0, 1));
      cfg_sel_i = 2'($urandom_range(0, 3));
      cfg_wdata_i = $urandom;
      c = ($urandom_range(0, 2) == 0);
      r = 1'($urandom_range(0, 1));
      commit_i = c;
      resync_i = r;
      step();
      if (c) exp_q.push_back(exp_beat(r));
    end
    step();
  endtask

  task automatic test_teardown();
    en_i = 1'b0;
    step();  // edge m
    step();  // edge m+1
    checks += 3;
    if (dds_rstn_o !== 1'b0) begin failures++; $display("FAIL down_rstn: got %b expected 0", dds_rstn_o); end
    if (dds_clk_en_o !== 1'b1) begin failures++; $display("FAIL down_clk_en_hold: got %b expected 1", dds_clk_en_o); end
    if (busy_o !== 1'b1) begin failures++; $display("FAIL down_busy: got %b expected 1", busy_o); end
    for (int k = 2; k <= S; k++) begin
      step();
      checks++;
      if (dds_clk_en_o !== 1'b1) begin failures++; $display("FAIL down_clk_en_early: step %0d got %b expected 1", k, dds_clk_en_o); end
    end
    step();  // edge m+1+S
    checks += 2;
    if (dds_clk_en_o !== 1'b0) begin failures++; $display("FAIL down_clk_en: got %b expected 0", dds_clk_en_o); end
    if (busy_o !== 1'b0) begin failures++; $display("FAIL down_busy_off: got %b expected 0", busy_o); end
  endtask

  task automatic test_off_commit();
    commit_i = 1'b1; resync_i = 1'b1; step();
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (pend_o !== 1'b1) begin failures++; $display("FAIL off_pend: got %b expected 1", pend_o); end
    end
    en_i = 1'b1;
    for (int e = 0; e <= S; e++) begin
      step();
      checks++;
      if (pend_o !== 1'b1) begin failures++; $display("FAIL clk_on_pend: edge %0d got %b expected 1", e, pend_o); end
    end
    exp_q.push_back(exp_beat(1'b1));
    step();
    checks += 2;
    if (phase_data_o[96] !== 1'b1) begin failures++; $display("FAIL off_resync: got %b expected 1", phase_data_o[96]); end
    if (pend_o !== 1'b0) begin failures++; $display("FAIL off_pend_clear: got %b expected 0", pend_o); end
    step();
    step();
  endtask

  task automatic test_abort();
    en_i = 1'b1;
    step();  // edge 0
    step();  // edge 1, one cycle into CLK_ON
    checks++;
    if (dds_clk_en_o !== 1'b1) begin failures++; $display("FAIL abort_clk_en: got %b expected 1", dds_clk_en_o); end
    en_i = 1'b0;
    for (int k = 0; k < S + 4; k++) begin
      step();
      checks++;
      if (dds_rstn_o !== 1'b0) begin failures++; $display("FAIL abort_rstn: step %0d got %b expected 0", k, dds_rstn_o); end
    end
    checks += 2;
    if (dds_clk_en_o !== 1'b0) begin failures++; $display("FAIL abort_clk_en_off: got %b expected 0", dds_clk_en_o); end
    if (busy_o !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_async_reset();
    test_bringup();
    cfg_wr_i = 1'b1; cfg_sel_i = 2'd2; cfg_wdata_i = 32'h12345678; commit_i = 1'b1; step();
    exp_q.push_back(exp_beat(1'b0));
    #2;
    adc_rst_i = 1'b1;
    #1;
    checks += 6;
    if (dds_clk_en_o !== 1'b0) begin failures++; $display("FAIL arst_clk_en: got %b expected 0", dds_clk_en_o); end
    if (dds_rstn_o !== 1'b0) begin failures++; $display("FAIL arst_rstn: got %b expected 0", dds_rstn_o); end
    if (phase_vld_o !== 1'b0) begin failures++; $display("FAIL arst_vld: got %b expected 0", phase_vld_o); end
    if (phase_data_o !== 97'h0) begin failures++; $display("FAIL arst_data: got %h expected 0", phase_data_o); end
    if (busy_o !== 1'b0) begin failures++; $display("FAIL arst_busy: got %b expected 0", busy_o); end
    if (pend_o !== 1'b0) begin failures++; $display("FAIL arst_pend: got %b expected 0", pend_o); end
    exp_q.delete();
    m_lo = 32'h0; m_hi = 32'h0; m_ofs = 32'h0;
    @(posedge clk_adc_125mhz);
    #1;
    adc_rst_i = 1'b0;
    test_bringup();
    checks++;
    if (phase_data_o !== 97'h0) begin failures++; $display("FAIL arst_shadow_clear: got %h expected 0", phase_data_o); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    checks++;
    if (phase_data_o !== 97'h0) begin failures++; $display("FAIL up_data_zero: got %h expected 0", phase_data_o); end
    test_commit();
    test_back_to_back();
    test_random();
    test_teardown();
    test_off_commit();
    test_teardown();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rb_dds_ctrl.md
# rb_dds_ctrl

Sequencer and configuration controller for one RadioBox DDS oscillator channel (clock-enable/reset bring-up and tear-down, plus atomic phase-configuration loading). Sits between the RadioBox register file and the DDS core's clock-enable, reset and phase-config stream input. Bus writes land in shadow registers. A commit transfers all shadow registers to the DDS as a single one-beat update, so the DDS never sees a half-written 48-bit increment.

## Interface
Parameters:
- SETTLE, 3: cycles the DDS is held in reset with clock enabled, on bring-up and on tear-down; legal range 1..15.

Ports (one clock; reset is asynchronous and active-high):
- clk_adc_125mhz  in  1  ADC-based 125 MHz clock; all logic on its rising edge.
- adc_rst_i  in  1  asynchronous active-high reset.
- en_i  in  1  channel enable level from the control register.
- cfg_wr_i  in  1  shadow write strobe.
- cfg_sel_i  in  2  shadow select: 0 = INC_LO, 1 = INC_HI, 2 = OFS, 3 = ignored.
- cfg_wdata_i  in  32  shadow write data.
- commit_i  in  1  commit request pulse.
- resync_i  in  1  request a phase resync with this commit; sampled together with commit_i.
- dds_clk_en_o  out  1  DDS aclken.
- dds_rstn_o  out  1  DDS aresetn.
- phase_vld_o  out  1  phase-config beat valid, one-cycle pulse.
- phase_data_o  out  97  {resync, ofs[47:0], inc[47:0]}.
- busy_o  out  1  high in CLK_ON and RST states.
- pend_o  out  1  a commit is pending delivery.

## Operation
- States: OFF, CLK_ON, RUN, RST.
- OFF: clk_en = 0, rstn = 0. Moves to CLK_ON when en_i = 1.
- CLK_ON: clk_en = 1, rstn = 0.
  - Counter loads SETTLE-1 on entry and counts down.
  - At 0 with en_i = 1, moves to RUN.
  - If en_i = 0 at any time, moves to RST.
- RUN: clk_en = 1, rstn = 1. Moves to RST when en_i = 0.
- RST: clk_en = 1, rstn = 0.
  - Counter loads SETTLE-1 on entry.
  - At 0, moves to OFF regardless of en_i. A re-enable passes through OFF for one cycle.
- Shadow registers:
  - INC_LO, INC_HI and OFS are 32 bits each; reset value 0.
  - They are written in any state and are never cleared by the FSM.
- Delivered values:
  - inc = {INC_HI, INC_LO[31:16]}.
  - ofs = {OFS, 16'h0000}.
- Commit:
  - commit_i sets pending and captures resync_i into a resync flag. The flag is OR-accumulated until delivery.
  - A write and a commit in the same cycle: the write is included in the commit.
- Delivery: in RUN with pending set, the controller does all of the following in one cycle:
  - drives phase_vld_o = 1;
  - drives phase_data_o from the shadow registers and the resync flag;
  - clears pending and the resync flag.
  - A commit_i in the same cycle as a delivery sets pending again for the next cycle.
- First RUN cycle: pending is forced set when entering RUN, so the DDS always receives the current configuration after a reset release.
- phase_data_o holds its last value between beats. Its resync bit reads 0 whenever phase_vld_o = 0.
- Leaving RUN with pending set keeps pending; it is delivered at the next RUN.

## Timing
- Reset values: dds_clk_en_o 0, dds_rstn_o 0, phase_vld_o 0, phase_data_o 0, busy_o 0, pend_o 0, state OFF.
- All outputs are registered.
- Bring-up, with en_i high sampled at edge 0:
  - Edge 1: dds_clk_en_o = 1.
  - Edge 1+SETTLE: dds_rstn_o = 1, phase_vld_o = 1, same cycle.
- Commit in RUN sampled at edge n: phase_vld_o = 1 at edge n+1. Sustained throughput is one beat per cycle.
- Tear-down, with en_i low sampled at edge m in RUN:
  - Edge m+1: dds_rstn_o = 0.
  - Edge m+1+SETTLE: dds_clk_en_o = 0.
- Reset asserted mid-operation: all outputs take their reset values immediately; shadows and pending clear.

## Structure
- Shared package rb_pkg:
  - state enum RB_DDS_ST_{OFF, CLK_ON, RUN, RST};
  - cfg_sel codes RB_CFG_INC_LO / INC_HI / OFS;
  - width constants RB_PHASE_W = 48 and RB_PHASE_DATA_W = 97.
- One sub-module, rb_dds_shadow: holds the three shadow registers, the write decode and the inc/ofs assembly. The FSM, pending logic and counter stay in rb_dds_ctrl.

## Test plan
- Reset, then en_i = 1 with SETTLE = 3:
  - dds_clk_en_o rises at edge 1.
  - dds_rstn_o and phase_vld_o rise at edge 4.
  - phase_data_o = 0.
- In RUN: write INC_LO = 0xABCD1234, INC_HI = 0x00112233, OFS = 0x80000000, then commit_i:
  - one phase_vld_o pulse;
  - inc = 0x00112233ABCD;
  - ofs = 0x800000000000;
  - resync bit = 0.
- Commit with resync_i = 1 while in OFF, then enable:
  - pend_o = 1 throughout OFF and CLK_ON;
  - exactly one beat in the first RUN cycle, with resync bit = 1.
- Write INC_HI and commit in the same cycle, with a second commit the next cycle:
  - two consecutive beats;
  - the first beat already carries the new INC_HI.
- en_i dropped one cycle into CLK_ON:
  - goes to RST, then OFF after SETTLE cycles;
  - dds_rstn_o never rises; no phase_vld_o.
- adc_rst_i asserted asynchronously in RUN: all outputs read 0 before the next clock edge.
